gpio_ctrl_v2: RTL and testbench
===============================

Name: gpio_ctrl_v2

Overview:
- Second-generation APB-attached GPIO controller. NUM_PINS is parametrised from 1 to 32.
- Adds the following:
  - atomic SET/CLR/TOGGLE writes to the output data
  - a per-pin programmable debounce filter
  - per-pin interrupt mode: rising, falling, both edges, high level or low level
  - write-1-to-clear interrupt status
- Sits on the peripheral APB bus. Drives pad output and output-enable. Raises one combined interrupt line to the PLIC.

Parameters:
- NUM_PINS, 8, number of GPIO pins (1..32).
- DEB_CNT_W, 4, width of the per-pin debounce counter. Stable threshold is 2^DEB_CNT_W-1 ticks.
- PRESC_W, 16, width of the debounce tick prescaler.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- PADDR  in  32  APB address. Only bits [5:0] are decoded.
- PWDATA  in  32  APB write data
- PENABLE  in  1  APB enable
- PWRITE  in  1  APB write
- PSEL  in  1  APB select
- PRDATA  out  32  APB read data
- PREADY  out  1  APB ready. Tied to 1.
- PSLVERR  out  1  APB error
- gpio_in  in  NUM_PINS  raw pad inputs (asynchronous)
- gpio_out  out  NUM_PINS  pad output data (registered)
- gpio_oe  out  NUM_PINS  pad output enable (registered)
- intr_pin  out  NUM_PINS  per-pin pending interrupt (INTR_STAT & INTR_EN)
- intr  out  1  OR-reduction of intr_pin

Behaviour:
- Reset: one clock, synchronous and active-high (rst sampled on the rising edge of clk). All registers, synchronisers, filters and the prescaler clear to 0. Outputs at reset: gpio_out=0, gpio_oe=0, intr_pin=0, intr=0, PRDATA=0, PSLVERR=0. A reset during an APB transfer aborts it with no register update.
- APB timing:
  - Zero wait states.
  - A write commits on the clk edge where PSEL & PENABLE & PWRITE are all high.
  - PRDATA is combinational during the access phase and 0 otherwise.
  - Register bits at and above NUM_PINS read as 0 and ignore writes.
- PSLVERR is asserted in the access phase for either of:
  - an unmapped offset
  - a write to DATA_IN
  An errored write has no effect.
- Register map (offset, access):
  - 0x00 DATA_OUT RW
  - 0x04 SET WO: DATA_OUT |= wdata
  - 0x08 CLR WO: DATA_OUT &= ~wdata
  - 0x0C TGL WO: DATA_OUT ^= wdata
  - 0x10 OE RW
  - 0x14 DATA_IN RO: filtered input
  - 0x18 INTR_EN RW
  - 0x1C INTR_TYPE RW: 1 = level, 0 = edge
  - 0x20 INTR_POL RW: 1 = rising/high, 0 = falling/low
  - 0x24 INTR_BOTH RW: 1 = both edges, edge type only
  - 0x28 INTR_STAT RW1C
  - 0x2C DEB_EN RW
  - 0x30 DEB_PRESC RW, PRESC_W bits
- Write-only registers SET, CLR and TGL read as 0.
- gpio_out and gpio_oe are DATA_OUT and OE registered. They update 1 cycle after the write commits.
- Input path, per pin:
  - A 2-flop synchroniser feeds the filter.
  - DEB_EN=0: filtered value = synchronised value, registered. DATA_IN changes 3 cycles after the gpio_in change.
  - DEB_EN=1: the filter counter resets to 0 whenever the synchronised value differs from the filtered value. It increments on each tick. When it reaches 2^DEB_CNT_W-1, the filtered value is updated and the counter cleared.
  - Tick: a global prescaler counts 0..DEB_PRESC and pulses when it wraps to 0. DEB_PRESC=0 gives a tick every cycle. Writing DEB_PRESC restarts the prescaler at 0.
- Event detection on the filtered value, comparing its current and previous value:
  - Edge event: (POL & rise) | (~POL & fall), or rise|fall if BOTH=1.
  - Level event: asserted on every cycle that filtered == POL.
- Interrupt status:
  - next STAT = (STAT & ~w1c_mask) | (event & INTR_EN). Event-set wins over a simultaneous W1C.
  - Level mode re-sets the bit the cycle after a clear while the level persists.
  - Disabled pins never latch status.
- Interrupt outputs are combinational from the registers:
  - intr_pin = STAT & INTR_EN
  - intr = |intr_pin
- Changing INTR_TYPE, POL or BOTH does not generate a spurious event. The previous-value register is independent of the mode bits.

Decomposition:
- Package gpio_v2_pkg holds:
  - register offset localparams (OFF_DATA_OUT .. OFF_DEB_PRESC)
  - typedef intr_mode_t {EDGE, LEVEL}
  - the APB decode helper width constant
- Sub-module gpio_pin_filter, instantiated once per pin via generate. Ports: clk, rst, tick, deb_en, raw_in. Outputs: filt, rise, fall. It contains the synchroniser, debounce counter and edge detector.
- The top level holds the APB decode, registers, prescaler and interrupt logic.

Test Plan:
- Reset / readback: assert rst mid-write of DATA_OUT=0xFF. Then read every register: all 0, PSLVERR=0, gpio_oe=0.
- Atomic ops: write DATA_OUT=0x0F, SET 0x30, CLR 0x03, TGL 0x81. Read 0xBD; gpio_out=0xBD one cycle after the last write. Then read SET → 0, read offset 0x34 → PSLVERR=1.
- Sync latency, no debounce:
  - Setup: pin 2 EN=1, TYPE=edge, POL=1. Drive gpio_in[2] 0→1.
  - DATA_IN[2]=1 after 3 cycles.
  - STAT[2]=1 and intr=1 one cycle later.
  - W1C 0x04 clears it. No re-assert.
- Debounce:
  - Setup: DEB_EN[0]=1, DEB_PRESC=1, DEB_CNT_W=4.
  - A 20-cycle pulse does not change DATA_IN[0].
  - A steady high changes DATA_IN[0] after 15 ticks (30 cycles) + 2 sync cycles.
- Level mode: pin 5 TYPE=level, POL=0, EN=1, input held low. W1C 0x20 → STAT[5] reads 1 again next cycle. Drive high and clear → stays 0.
- Both edges + collision: pin 1 with BOTH=1 is toggled → status set on rise and on fall. A W1C in the same cycle as a new event leaves STAT[1]=1.

Source files
------------

// File: rtl/gpio_ctrl_v2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_v2_pkg
// Description : Shared constants and types for the gpio_ctrl_v2 controller:
//               APB register offsets and the interrupt mode encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_v2_pkg;

    // Number of low PADDR bits that take part in register decode
    localparam int APB_DEC_W = 6;

    localparam logic [APB_DEC_W-1:0] OFF_DATA_OUT  = 6'h00;
    localparam logic [APB_DEC_W-1:0] OFF_SET       = 6'h04;
    localparam logic [APB_DEC_W-1:0] OFF_CLR       = 6'h08;
    localparam logic [APB_DEC_W-1:0] OFF_TGL       = 6'h0C;
    localparam logic [APB_DEC_W-1:0] OFF_OE        = 6'h10;
    localparam logic [APB_DEC_W-1:0] OFF_DATA_IN   = 6'h14;
    localparam logic [APB_DEC_W-1:0] OFF_INTR_EN   = 6'h18;
    localparam logic [APB_DEC_W-1:0] OFF_INTR_TYPE = 6'h1C;
    localparam logic [APB_DEC_W-1:0] OFF_INTR_POL  = 6'h20;
    localparam logic [APB_DEC_W-1:0] OFF_INTR_BOTH = 6'h24;
    localparam logic [APB_DEC_W-1:0] OFF_INTR_STAT = 6'h28;
    localparam logic [APB_DEC_W-1:0] OFF_DEB_EN    = 6'h2C;
    localparam logic [APB_DEC_W-1:0] OFF_DEB_PRESC = 6'h30;

    // INTR_TYPE bit meaning: 0 = edge triggered, 1 = level triggered
    typedef enum logic {
        EDGE  = 1'b0,
        LEVEL = 1'b1
    } intr_mode_t;

endpackage
`default_nettype wire

// File: rtl/gpio_ctrl_v2_if.sv
`default_nettype none
// ============================================================================
// Module      : gpio_ctrl_v2_if
// Description : APB bus bundle between the peripheral bus and gpio_ctrl_v2.
// Revision    : 1.0 - initial release
// ============================================================================
interface gpio_ctrl_v2_if;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PENABLE;
    logic        PWRITE;
    logic        PSEL;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PADDR, PWDATA, PENABLE, PWRITE, PSEL,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PENABLE, PWRITE, PSEL,
        output PRDATA, PREADY, PSLVERR
    );
endinterface
`default_nettype wire

// File: rtl/gpio_ctrl_v2_pin_filter.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pin_filter
// Description : One GPIO input lane: 2-flop synchroniser, optional debounce
//               filter and rise/fall detection on the filtered value.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_pin_filter #(
    parameter int DEB_CNT_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic deb_en,
    input  logic raw_in,
    output logic filt,
    output logic rise,
    output logic fall
);

    // The filtered value flips on the tick that brings the count to all-ones
    localparam logic [DEB_CNT_W-1:0] C_CNT_LAST = {DEB_CNT_W{1'b1}} - 1'b1;

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_filt;
    logic                 r_prev;
    logic [DEB_CNT_W-1:0] r_cnt;

    // Bring the asynchronous pad value into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= raw_in;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: adopt a new level only after it stays different for a full count of ticks
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt <= 1'b0;
            r_cnt  <= '0;
        end else if (!deb_en) begin
            r_filt <= r_sync2;
            r_cnt  <= '0;
        end else if (r_sync2 == r_filt) begin
            r_cnt  <= '0;
        end else if (tick) begin
            if (r_cnt == C_CNT_LAST) begin
                r_filt <= r_sync2;
                r_cnt  <= '0;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
            end
        end
    end

    // Previous filtered value, kept independent of any interrupt mode bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= r_filt;
        end
    end

    assign filt = r_filt;
    assign rise = r_filt & ~r_prev;
    assign fall = ~r_filt & r_prev;

endmodule
`default_nettype wire

// File: rtl/gpio_ctrl_v2.sv
`default_nettype none
// ============================================================================
// Module      : gpio_ctrl_v2
// Description : APB GPIO controller with atomic output ops, per-pin debounce
//               and per-pin edge/level interrupts with W1C status.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_ctrl_v2
    import gpio_v2_pkg::*;
#(
    parameter int NUM_PINS  = 8,
    parameter int DEB_CNT_W = 4,
    parameter int PRESC_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    gpio_ctrl_v2_if.slave       apb,
    input  logic [NUM_PINS-1:0] gpio_in,
    output logic [NUM_PINS-1:0] gpio_out,
    output logic [NUM_PINS-1:0] gpio_oe,
    output logic [NUM_PINS-1:0] intr_pin,
    output logic                intr
);

    logic [NUM_PINS-1:0]  r_dout, r_oe, r_ien, r_itype, r_ipol, r_iboth, r_stat, r_deb_en;
    logic [PRESC_W-1:0]   r_presc, r_pcnt;
    logic [NUM_PINS-1:0]  w_filt, w_rise, w_fall, w_edge_ev, w_event, w_w1c, w_wd;
    logic [APB_DEC_W-1:0] w_off;
    logic [31:0]          w_rdata;
    logic                 w_access, w_mapped, w_err, w_we, w_tick;
    logic                 w_unused;

    assign w_access = apb.PSEL & apb.PENABLE;
    assign w_off    = apb.PADDR[APB_DEC_W-1:0];
    assign w_wd     = apb.PWDATA[NUM_PINS-1:0];
    assign w_unused = ^{apb.PADDR[31:APB_DEC_W], apb.PWDATA};

    // Address decode and read mux; write-only registers read back as zero
    always_comb begin
        w_rdata  = '0;
        w_mapped = 1'b1;
        case (w_off)
            OFF_DATA_OUT:  w_rdata[NUM_PINS-1:0] = r_dout;
            OFF_SET:       w_rdata = '0;
            OFF_CLR:       w_rdata = '0;
            OFF_TGL:       w_rdata = '0;
            OFF_OE:        w_rdata[NUM_PINS-1:0] = r_oe;
            OFF_DATA_IN:   w_rdata[NUM_PINS-1:0] = w_filt;
            OFF_INTR_EN:   w_rdata[NUM_PINS-1:0] = r_ien;
            OFF_INTR_TYPE: w_rdata[NUM_PINS-1:0] = r_itype;
            OFF_INTR_POL:  w_rdata[NUM_PINS-1:0] = r_ipol;
            OFF_INTR_BOTH: w_rdata[NUM_PINS-1:0] = r_iboth;
            OFF_INTR_STAT: w_rdata[NUM_PINS-1:0] = r_stat;
            OFF_DEB_EN:    w_rdata[NUM_PINS-1:0] = r_deb_en;
            OFF_DEB_PRESC: w_rdata[PRESC_W-1:0]  = r_presc;
            default:       w_mapped = 1'b0;
        endcase
    end

    // DATA_IN is read-only, so writing it is an error just like an unmapped offset
    assign w_err = w_access & (~w_mapped | (apb.PWRITE & (w_off == OFF_DATA_IN)));
    assign w_we  = w_access & apb.PWRITE & ~w_err;
    assign w_w1c = (w_we && (w_off == OFF_INTR_STAT)) ? w_wd : '0;

    assign apb.PRDATA  = w_access ? w_rdata : '0;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = w_err;

    // Control register writes, including the atomic set/clear/toggle views of DATA_OUT
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout   <= '0;
            r_oe     <= '0;
            r_ien    <= '0;
            r_itype  <= '0;
            r_ipol   <= '0;
            r_iboth  <= '0;
            r_deb_en <= '0;
            r_presc  <= '0;
        end else if (w_we) begin
            case (w_off)
                OFF_DATA_OUT:  r_dout   <= w_wd;
                OFF_SET:       r_dout   <= r_dout | w_wd;
                OFF_CLR:       r_dout   <= r_dout & ~w_wd;
                OFF_TGL:       r_dout   <= r_dout ^ w_wd;
                OFF_OE:        r_oe     <= w_wd;
                OFF_INTR_EN:   r_ien    <= w_wd;
                OFF_INTR_TYPE: r_itype  <= w_wd;
                OFF_INTR_POL:  r_ipol   <= w_wd;
                OFF_INTR_BOTH: r_iboth  <= w_wd;
                OFF_DEB_EN:    r_deb_en <= w_wd;
                OFF_DEB_PRESC: r_presc  <= apb.PWDATA[PRESC_W-1:0];
                default:       ;
            endcase
        end
    end

    // Pad drivers follow the control registers one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_out <= '0;
            gpio_oe  <= '0;
        end else begin
            gpio_out <= r_dout;
            gpio_oe  <= r_oe;
        end
    end

    // Debounce tick prescaler: counts 0..DEB_PRESC, restarted by a DEB_PRESC write
    assign w_tick = (r_pcnt == r_presc);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt <= '0;
        end else if (w_we && (w_off == OFF_DEB_PRESC)) begin
            r_pcnt <= '0;
        end else if (w_tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

    assign w_edge_ev = (r_iboth & (w_rise | w_fall)) |
                       (~r_iboth & ((r_ipol & w_rise) | (~r_ipol & w_fall)));

    for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_pin
        gpio_pin_filter #(
            .DEB_CNT_W (DEB_CNT_W)
        ) u_filter (
            .clk    (clk),
            .rst    (rst),
            .tick   (w_tick),
            .deb_en (r_deb_en[gi]),
            .raw_in (gpio_in[gi]),
            .filt   (w_filt[gi]),
            .rise   (w_rise[gi]),
            .fall   (w_fall[gi])
        );

        assign w_event[gi] = (intr_mode_t'(r_itype[gi]) == LEVEL) ?
                             (w_filt[gi] == r_ipol[gi]) : w_edge_ev[gi];
    end

    // Interrupt status: a new event on an enabled pin beats a simultaneous W1C
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat <= '0;
        end else begin
            r_stat <= (r_stat & ~w_w1c) | (w_event & r_ien);
        end
    end

    assign intr_pin = r_stat & r_ien;
    assign intr     = |intr_pin;

endmodule
`default_nettype wire

// File: tb/tb_gpio_ctrl_v2.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_ctrl_v2
// Description : Self-checking bench for gpio_ctrl_v2 with a register-map level
//               reference model, directed scenarios and a randomised phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_ctrl_v2;

    localparam int N          = 8;
    localparam int DEB_STABLE = 15;
    localparam bit [31:0] PIN_MASK = 32'h0000_00FF;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] gpio_in, gpio_out, gpio_oe, intr_pin;
    logic         intr;
    int           checks = 0;
    int           errors = 0;

    gpio_ctrl_v2_if bus ();

    gpio_ctrl_v2 #(
        .NUM_PINS  (N),
        .DEB_CNT_W (4),
        .PRESC_W   (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .apb      (bus),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .intr_pin (intr_pin),
        .intr     (intr)
    );

    always #5 clk = ~clk;

    // Reference model: register file indexed by offset/4, plus per-pin input lanes
    bit [31:0]   m_reg [13];
    bit          m_s1 [N], m_s2 [N], m_filt [N], m_prev [N];
    int          m_cnt [N];
    int unsigned m_pcnt;
    bit [N-1:0]  m_gout, m_goe, m_ev;
    bit [31:0]   m_w1c, m_d;
    bit          m_tick, m_wr_ok;
    logic [5:0]  m_off;

    function automatic bit off_err(input logic [5:0] off, input logic wr);
        return (off[1:0] != 2'b00) || (off > 6'h30) || (wr && off == 6'h14);
    endfunction

    function automatic bit [31:0] m_din();
        bit [31:0] r = 0;
        for (int i = 0; i < N; i++) r[i] = m_filt[i];
        return r;
    endfunction

    function automatic bit [31:0] m_read(input logic [5:0] off);
        if (off_err(off, 1'b0)) return 0;
        if (off == 6'h04 || off == 6'h08 || off == 6'h0C) return 0;
        if (off == 6'h14) return m_din();
        return m_reg[off[5:2]];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            foreach (m_reg[k]) m_reg[k] = 0;
            for (int i = 0; i < N; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_filt[i] = 0; m_prev[i] = 0; m_cnt[i] = 0;
            end
            m_pcnt = 0; m_gout = 0; m_goe = 0;
        end else begin
            m_tick = (m_pcnt == m_reg[12]);
            for (int i = 0; i < N; i++) begin
                if (m_reg[7][i])      m_ev[i] = (m_filt[i] == m_reg[8][i]);
                else if (m_reg[9][i]) m_ev[i] = (m_filt[i] != m_prev[i]);
                else if (m_reg[8][i]) m_ev[i] = m_filt[i] && !m_prev[i];
                else                  m_ev[i] = !m_filt[i] && m_prev[i];
            end
            m_gout = m_reg[0][N-1:0];
            m_goe  = m_reg[4][N-1:0];
            for (int i = 0; i < N; i++) begin
                m_prev[i] = m_filt[i];
                if (!m_reg[11][i]) begin
                    m_filt[i] = m_s2[i]; m_cnt[i] = 0;
                end else if (m_s2[i] == m_filt[i]) begin
                    m_cnt[i] = 0;
                end else if (m_tick) begin
                    m_cnt[i]++;
                    if (m_cnt[i] == DEB_STABLE) begin
                        m_filt[i] = m_s2[i]; m_cnt[i] = 0;
                    end
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = gpio_in[i];
            end
            m_pcnt = m_tick ? 0 : m_pcnt + 1;
            m_off   = bus.PADDR[5:0];
            m_wr_ok = bus.PSEL && bus.PENABLE && bus.PWRITE && !off_err(m_off, 1'b1);
            m_d     = bus.PWDATA & PIN_MASK;
            m_w1c   = (m_wr_ok && m_off == 6'h28) ? m_d : 0;
            m_reg[10] = (m_reg[10] & ~m_w1c) | 32'(m_ev & m_reg[6][N-1:0]);
            if (m_wr_ok) begin
                case (m_off)
                    6'h04: m_reg[0] = m_reg[0] | m_d;
                    6'h08: m_reg[0] = m_reg[0] & ~m_d;
                    6'h0C: m_reg[0] = m_reg[0] ^ m_d;
                    6'h28: ;
                    6'h30: begin m_reg[12] = bus.PWDATA & 32'hFFFF; m_pcnt = 0; end
                    default: m_reg[m_off[5:2]] = m_d;
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance n cycles, checking pad/interrupt outputs and the bus on each falling edge
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            chk("gpio_out", 32'(gpio_out), 32'(m_gout));
            chk("gpio_oe", 32'(gpio_oe), 32'(m_goe));
            chk("intr_pin", 32'(intr_pin), m_reg[10] & m_reg[6]);
            chk("intr", 32'(intr), 32'(|(m_reg[10] & m_reg[6])));
            if (bus.PSEL && bus.PENABLE) begin
                chk("pslverr", 32'(bus.PSLVERR), 32'(off_err(bus.PADDR[5:0], bus.PWRITE)));
                if (!bus.PWRITE) chk("prdata", bus.PRDATA, m_read(bus.PADDR[5:0]));
            end else begin
                chk("prdata_idle", bus.PRDATA, 32'h0);
                chk("pslverr_idle", 32'(bus.PSLVERR), 32'h0);
            end
        end
    endtask

    task automatic apb_xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output logic err);
        cyc();
        bus.PSEL = 1'b1; bus.PWRITE = wr; bus.PADDR = a; bus.PWDATA = d; bus.PENABLE = 1'b0;
        cyc();
        bus.PENABLE = 1'b1;
        #1;
        rd  = bus.PRDATA;
        err = bus.PSLVERR;
        chk("acc_pslverr", 32'(err), 32'(off_err(a[5:0], wr)));
        if (!wr) chk("acc_prdata", rd, m_read(a[5:0]));
        cyc();
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        logic        err;
        apb_xfer(1'b1, a, d, rd, err);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] data, output logic err);
        apb_xfer(1'b0, a, 32'h0, data, err);
    endtask

    // Hold a continuous read of DATA_IN so every cycle exposes the filtered inputs
    task automatic monitor_data_in();
        bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b0; bus.PADDR = 32'h14;
    endtask

    task automatic bus_idle();
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] data;
        logic        err;
        int          lat;
        logic [5:0]  off;

        rst = 1'b1; gpio_in = '0;
        bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = 0; bus.PWDATA = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc(2);

        // Reset arriving during the access phase of a DATA_OUT write
        bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = 32'h0; bus.PWDATA = 32'hFF;
        cyc();
        bus.PENABLE = 1'b1; rst = 1'b1;
        cyc();
        bus_idle(); rst = 1'b0;
        cyc();
        for (int a = 0; a <= 'h30; a += 4) begin
            rd(32'(a), data, err);
            chk($sformatf("reset_read_%02h", a), data, 32'h0);
            chk($sformatf("reset_err_%02h", a), 32'(err), 32'h0);
        end
        chk("reset_gpio_oe", 32'(gpio_oe), 32'h0);

        // Atomic set/clear/toggle on DATA_OUT
        wr(32'h00, 32'h0F);
        wr(32'h04, 32'h30);
        wr(32'h08, 32'h03);
        wr(32'h0C, 32'h81);
        chk("gpio_out_before_update", 32'(gpio_out), 32'h3C);
        cyc();
        chk("gpio_out_after_tgl", 32'(gpio_out), 32'hBD);
        rd(32'h00, data, err);
        chk("data_out_atomic", data, 32'hBD);
        rd(32'h04, data, err);
        chk("set_reads_zero", data, 32'h0);
        rd(32'h34, data, err);
        chk("unmapped_err", 32'(err), 32'h1);
        wr(32'h14, 32'hFF);
        rd(32'h14, data, err);
        chk("data_in_write_ignored", data, 32'h0);

        // Synchroniser latency and a rising-edge interrupt on pin 2
        wr(32'h18, 32'h04);
        wr(32'h1C, 32'h00);
        wr(32'h20, 32'h04);
        monitor_data_in();
        gpio_in[2] = 1'b1;
        cyc(); chk("sync_lat_1", 32'(bus.PRDATA[2]), 32'h0);
        cyc(); chk("sync_lat_2", 32'(bus.PRDATA[2]), 32'h0);
        cyc(); chk("sync_lat_3", 32'(bus.PRDATA[2]), 32'h1);
        chk("intr_not_yet", 32'(intr), 32'h0);
        cyc(); chk("intr_edge_pin2", 32'(intr), 32'h1);
        bus_idle();
        wr(32'h28, 32'h04);
        cyc(5);
        chk("w1c_no_reassert", 32'(intr), 32'h0);

        // Debounce on pin 0 with a tick every second cycle
        wr(32'h2C, 32'h01);
        wr(32'h30, 32'h01);
        monitor_data_in();
        gpio_in[0] = 1'b1;
        cyc(20);
        gpio_in[0] = 1'b0;
        cyc(40);
        chk("deb_pulse_rejected", 32'(bus.PRDATA[0]), 32'h0);
        gpio_in[0] = 1'b1;
        lat = 0;
        while (lat < 60 && bus.PRDATA[0] !== 1'b1) begin
            cyc();
            lat++;
        end
        chk("deb_latency_window", 32'(lat >= 29 && lat <= 33), 32'h1);
        bus_idle();
        wr(32'h2C, 32'h00);

        // Low-level interrupt on pin 5 re-asserts after W1C while the level persists
        wr(32'h1C, 32'h20);
        wr(32'h18, 32'h24);
        cyc(2);
        rd(32'h28, data, err);
        chk("level_stat_set", 32'(data[5]), 32'h1);
        wr(32'h28, 32'h20);
        rd(32'h28, data, err);
        chk("level_stat_reasserts", 32'(data[5]), 32'h1);
        gpio_in[5] = 1'b1;
        cyc(5);
        wr(32'h28, 32'h20);
        rd(32'h28, data, err);
        chk("level_stat_cleared", 32'(data[5]), 32'h0);

        // Both-edge interrupt on pin 1, then a W1C landing on the same cycle as an event
        wr(32'h24, 32'h02);
        wr(32'h18, 32'h26);
        gpio_in[1] = 1'b1;
        cyc(5);
        rd(32'h28, data, err);
        chk("both_rise", 32'(data[1]), 32'h1);
        wr(32'h28, 32'h02);
        rd(32'h28, data, err);
        chk("both_cleared", 32'(data[1]), 32'h0);
        gpio_in[1] = 1'b0;
        cyc(5);
        rd(32'h28, data, err);
        chk("both_fall", 32'(data[1]), 32'h1);
        wr(32'h28, 32'h02);
        gpio_in[1] = 1'b1;
        cyc();
        wr(32'h28, 32'h02);
        rd(32'h28, data, err);
        chk("collision_event_wins", 32'(data[1]), 32'h1);

        // Randomised register traffic and pad activity against the model
        repeat (250) begin
            if ($urandom_range(0, 3) == 0) gpio_in = gpio_in ^ N'(1 << $urandom_range(0, N - 1));
            off = 6'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 15) == 0) off = off | 6'h1;
            data = $urandom();
            if (off == 6'h30) data = 32'($urandom_range(0, 3));
            apb_xfer(1'($urandom_range(0, 1)), {26'($urandom()), off}, data, data, err);
        end
        cyc(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
